mem_port_arbiter: RTL and testbench

Sequencing arbiter that shares the single-port unified instruction/data memory between two requesters: the instruction fetch requester and the load/store (data) requester.
- Each requester uses a req/gnt handshake with a registered response pulse.
- The arbiter owns every memory control signal: address, write data, read/write enables, funct3.
- The block sits between the fetch/execute logic and the memory instance. It replaces the ad-hoc PC/ALU address mux and the instruction-hold register.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Sequencing arbiter sharing one single-port instruction/data memory between
// the instruction fetch requester and the load/store requester. Each
// transaction runs IDLE (grant) -> ACCESS (MEM_LATENCY cycles) -> RESP (one
// cycle). Data has priority, but only until MAX_DATA_STREAK consecutive data
// grants have gone by while fetch was waiting.
module mem_port_arbiter #(
  parameter int AWIDTH          = 32,
  parameter int DWIDTH          = 32,
  parameter int MEM_LATENCY     = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DWIDTH-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  input  logic [2:0]        d_funct3_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] d_rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LATENCY - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);
  localparam logic [2:0]    F3_WORD    = 3'b010;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [SW-1:0]     streak_q;
  logic              owner_data_q;
  logic              we_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [2:0]        funct3_q;
  logic [DWIDTH-1:0] if_rdata_q, d_rdata_q;
  logic              grant_d, grant_f;
  logic              in_access, last_access;

  assign in_access   = (state_q == ACCESS);
  assign last_access = in_access && (cnt_q == '0);

  // Next-state and grant decision; grants exist only in IDLE.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    grant_d = 1'b0;
    grant_f = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req_i && (!if_req_i || streak_q != STREAK_MAX)) grant_d = 1'b1;
        else if (if_req_i)                                     grant_f = 1'b1;
        if (grant_d || grant_f) state_d = ACCESS;
      end
      ACCESS:  if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Transaction latch, latency counter, response data and data-streak counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      streak_q     <= '0;
      owner_data_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      funct3_q     <= F3_WORD;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      if (grant_d) begin
        owner_data_q <= 1'b1;
        we_q         <= d_we_i;
        addr_q       <= d_addr_i;
        wdata_q      <= d_wdata_i;
        funct3_q     <= d_funct3_i;
        cnt_q        <= CNT_LOAD;
        if (!if_req_i)                   streak_q <= '0;
        else if (streak_q != STREAK_MAX) streak_q <= streak_q + 1'b1;
      end else if (grant_f) begin
        owner_data_q <= 1'b0;
        we_q         <= 1'b0;
        addr_q       <= if_addr_i;
        wdata_q      <= '0;
        funct3_q     <= F3_WORD;
        cnt_q        <= CNT_LOAD;
        streak_q     <= '0;
      end else if (in_access && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (last_access) begin
        if (owner_data_q) d_rdata_q  <= we_q ? '0 : mem_data_i;
        else              if_rdata_q <= mem_data_i;
      end
    end
  end

  // Memory port is driven only during ACCESS; idle values otherwise.
  assign mem_addr_o     = in_access ? addr_q   : '0;
  assign mem_data_o     = in_access ? wdata_q  : '0;
  assign mem_funct3_o   = in_access ? funct3_q : F3_WORD;
  assign mem_read_en_o  = in_access && !we_q;
  assign mem_write_en_o = in_access && we_q && (cnt_q == CNT_LOAD);

  assign if_gnt_o    = grant_f;
  assign d_gnt_o     = grant_d;
  assign if_rvalid_o = (state_q == RESP) && !owner_data_q;
  assign d_rvalid_o  = (state_q == RESP) && owner_data_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: one instance at MEM_LATENCY=1 with
// a small memory model, one at MEM_LATENCY=3 with memory data driven per cycle.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Latency-1 instance signals
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [2:0]  d_funct3 = 3'b010;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_re, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wd, mem_rd;
  logic [2:0]  mem_f3;

  // Latency-3 instance signals
  logic        l3_d_req = 0;
  logic [31:0] l3_mem_rd = 0;
  logic        l3_if_gnt, l3_if_rvalid, l3_d_gnt, l3_d_rvalid, l3_re, l3_we, l3_busy;
  logic [31:0] l3_if_rdata, l3_d_rdata, l3_addr, l3_wd;
  logic [2:0]  l3_f3;

  logic [31:0] mem_arr [256];
  assign mem_rd = mem_arr[mem_addr[9:2]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
      mem_arr[0] <= 32'h0000_0013;
    end else if (mem_we) begin
      mem_arr[mem_addr[9:2]] <= mem_wd;
    end
  end

  mem_port_arbiter #(.MEM_LATENCY(1), .MAX_DATA_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_funct3_i(d_funct3), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wd), .mem_read_en_o(mem_re),
    .mem_write_en_o(mem_we), .mem_funct3_o(mem_f3), .mem_data_i(mem_rd),
    .busy_o(busy)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .MAX_DATA_STREAK(4)) dut3 (
    .clk(clk), .rst(rst),
    .if_req_i(1'b0), .if_addr_i(32'h0), .if_gnt_o(l3_if_gnt),
    .if_rvalid_o(l3_if_rvalid), .if_rdata_o(l3_if_rdata),
    .d_req_i(l3_d_req), .d_we_i(1'b0), .d_addr_i(32'h0000_0200), .d_wdata_i(32'h0),
    .d_funct3_i(3'b010), .d_gnt_o(l3_d_gnt), .d_rvalid_o(l3_d_rvalid), .d_rdata_o(l3_d_rdata),
    .mem_addr_o(l3_addr), .mem_data_o(l3_wd), .mem_read_en_o(l3_re),
    .mem_write_en_o(l3_we), .mem_funct3_o(l3_f3), .mem_data_i(l3_mem_rd),
    .busy_o(l3_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; drive and sample 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [9:0] seq;
    int         n;

    repeat (3) cyc();
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_if_gnt", if_gnt, 0);
    check("rst_read_en", mem_re, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_funct3", mem_f3, 3'b010);
    check("rst_if_rdata", if_rdata, 0);
    cyc();

    // 1. Fetch only
    if_req = 1; if_addr = 32'h0100_0000;
    #1;
    check("t1_if_gnt", if_gnt, 1);
    check("t1_d_gnt", d_gnt, 0);
    cyc(); if_req = 0; #1;
    check("t1_read_en", mem_re, 1);
    check("t1_addr", mem_addr, 32'h0100_0000);
    check("t1_write_en", mem_we, 0);
    check("t1_busy_acc", busy, 1);
    cyc();
    check("t1_if_rvalid", if_rvalid, 1);
    check("t1_if_rdata", if_rdata, 32'h0000_0013);
    check("t1_d_rvalid", d_rvalid, 0);
    check("t1_read_en_resp", mem_re, 0);
    cyc();
    check("t1_busy_done", busy, 0);
    check("t1_if_rvalid_done", if_rvalid, 0);

    // 2. Store then load of the same word
    d_req = 1; d_we = 1; d_addr = 32'h0100_0100; d_wdata = 32'hDEAD_BEEF; d_funct3 = 3'b010;
    #1;
    check("t2_st_gnt", d_gnt, 1);
    cyc(); d_req = 0; #1;
    check("t2_st_write_en", mem_we, 1);
    check("t2_st_read_en", mem_re, 0);
    check("t2_st_addr", mem_addr, 32'h0100_0100);
    check("t2_st_data", mem_wd, 32'hDEAD_BEEF);
    cyc();
    check("t2_st_rvalid", d_rvalid, 1);
    check("t2_st_write_en_off", mem_we, 0);
    check("t2_st_rdata", d_rdata, 0);
    cyc();
    d_req = 1; d_we = 0; d_wdata = 0;
    #1;
    check("t2_ld_gnt", d_gnt, 1);
    cyc(); d_req = 0; #1;
    check("t2_ld_read_en", mem_re, 1);
    check("t2_ld_write_en", mem_we, 0);
    cyc();
    check("t2_ld_rvalid", d_rvalid, 1);
    check("t2_ld_rdata", d_rdata, 32'hDEAD_BEEF);
    cyc();

    // 3. Simultaneous fetch and load with streak 0: data first
    if_req = 1; if_addr = 32'h0100_0000; d_req = 1; d_we = 0; d_addr = 32'h0100_0100;
    #1;
    check("t3_d_gnt", d_gnt, 1);
    check("t3_if_gnt_blocked", if_gnt, 0);
    cyc(); d_req = 0; #1;
    check("t3_if_gnt_acc", if_gnt, 0);
    cyc();
    check("t3_d_rvalid", d_rvalid, 1);
    check("t3_if_rvalid_quiet", if_rvalid, 0);
    check("t3_if_gnt_resp", if_gnt, 0);
    check("t3_d_rdata", d_rdata, 32'hDEAD_BEEF);
    cyc();
    check("t3_if_gnt", if_gnt, 1);
    check("t3_d_rvalid_off", d_rvalid, 0);
    cyc(); if_req = 0;
    cyc();
    check("t3_if_rvalid", if_rvalid, 1);
    check("t3_d_rvalid_quiet", d_rvalid, 0);
    check("t3_if_rdata", if_rdata, 32'h0000_0013);
    cyc();

    // 4. Fairness with both requesters held continuously
    if_req = 1; d_req = 1; d_we = 0;
    #1;
    seq = '0; n = 0;
    for (int i = 0; i < 60 && n < 10; i++) begin
      if (if_gnt && d_gnt) check("t4_double_gnt", 1, 0);
      if (if_gnt || d_gnt) begin
        seq = {seq[8:0], d_gnt};
        n++;
      end
      cyc();
    end
    if_req = 0; d_req = 0;
    check("t4_grant_count", n, 10);
    check("t4_sequence", {22'h0, seq}, {22'h0, 10'b1111011110});
    repeat (3) cyc();

    // 5. Latency 3 load
    l3_d_req = 1;
    #1;
    check("t5_gnt", l3_d_gnt, 1);
    cyc(); l3_d_req = 0; l3_mem_rd = 32'h1111_1111; #1;
    check("t5_re_c1", l3_re, 1);
    cyc(); l3_mem_rd = 32'h2222_2222; #1;
    check("t5_re_c2", l3_re, 1);
    check("t5_rvalid_early", l3_d_rvalid, 0);
    cyc(); l3_mem_rd = 32'h3333_3333; #1;
    check("t5_re_c3", l3_re, 1);
    check("t5_addr", l3_addr, 32'h0000_0200);
    cyc(); l3_mem_rd = 32'h4444_4444; #1;
    check("t5_rvalid", l3_d_rvalid, 1);
    check("t5_rdata", l3_d_rdata, 32'h3333_3333);
    check("t5_re_off", l3_re, 0);
    cyc();

    // 6. Reset during the first ACCESS cycle of a byte store
    d_req = 1; d_we = 1; d_addr = 32'h0100_0104; d_wdata = 32'h0000_00AB; d_funct3 = 3'b000;
    #1;
    check("t6_gnt", d_gnt, 1);
    cyc(); d_req = 0; #1;
    check("t6_write_en", mem_we, 1);
    check("t6_funct3", mem_f3, 3'b000);
    rst = 1;
    cyc();
    check("t6_busy", busy, 0);
    check("t6_write_en_off", mem_we, 0);
    check("t6_d_rvalid", d_rvalid, 0);
    check("t6_addr", mem_addr, 0);
    check("t6_funct3_idle", mem_f3, 3'b010);
    check("t6_d_rdata", d_rdata, 0);
    rst = 0;
    cyc();
    check("t6_no_rvalid", d_rvalid, 0);
    check("t6_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
